// File: rtl/button_debounce_pkg.sv
// Shared constants and FSM encoding for the pushbutton debouncer.
package button_debounce_pkg;

  // Reference clock frequency of CLOCK_50.
  localparam int unsigned CLK_FREQ_HZ = 50000000;

  // 20 ms debounce window at 50 MHz.
  localparam int unsigned DEFAULT_DB_CYCLES = 1000000;

  // 1 s long-press threshold at 50 MHz.
  localparam int unsigned DEFAULT_LONG_CYCLES = 50000000;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Metastability filter: d -> meta_q -> q.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizes the raw pin, accepts a level change only after
// DB_CYCLES stable samples, and emits one-cycle press/release pulses.
// Optional long-press detection is enabled by defining BUTTON_DEBOUNCE_LONG_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEFAULT_DB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  // Not-pressed level of the raw pin, so reset never looks like a press.
  localparam logic IdleLevel = (ACTIVE_LOW != 0);

  logic           btn_sync;
  logic           pressed_s;
  db_state_t      state_q;
  logic [DbW-1:0] db_cnt_q;
  logic           press_set;
  logic           release_set;

  sync_2ff #(
    .RST_VAL (IdleLevel)
  ) u_sync (
    .clk   (CLOCK_50),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign pressed_s = (ACTIVE_LOW != 0) ? ~btn_sync : btn_sync;

  // Decode the cycles on which a press or release is accepted.
  always_comb begin
    press_set   = 1'b0;
    release_set = 1'b0;
    if (db_cnt_q == DbLast) begin
      press_set   = (state_q == StPressWait) && pressed_s;
      release_set = (state_q == StReleaseWait) && !pressed_s;
    end
  end

  // Debounce FSM with registered level and pulse outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StIdle;
      db_cnt_q    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pressed_s) begin
            state_q  <= StPressWait;
            db_cnt_q <= '0;
          end
        end
        StPressWait: begin
          if (!pressed_s) begin
            state_q <= StIdle;
          end else if (press_set) begin
            state_q   <= StPressed;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
          end
        end
        StPressed: begin
          if (!pressed_s) begin
            state_q  <= StReleaseWait;
            db_cnt_q <= '0;
          end
        end
        StReleaseWait: begin
          if (pressed_s) begin
            // Release glitch: level stays high and no new press is reported.
            state_q <= StPressed;
          end else if (release_set) begin
            state_q     <= StIdle;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_EN
  localparam int unsigned LongW = $clog2(LONG_CYCLES + 1);
  localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYCLES - 1);

  logic [LongW-1:0] long_cnt_q;
  logic             long_q;

  // Long-press timer: restarts with each accepted press, saturates at LongLast.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_set) begin
        long_cnt_q <= '0;
      end else if (btn_level && (long_cnt_q != LongLast)) begin
        long_cnt_q <= long_cnt_q + LongW'(1);
        if ((long_cnt_q + LongW'(1)) == LongLast) begin
          long_q <= 1'b1;
        end
      end
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with DB_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
// Define BUTTON_DEBOUNCE_LONG_EN for both bench and RTL to exercise the long-press pulse.
module tb_button_debounce;

  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 20;

  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KLong    = 2;

  typedef struct {
    logic raw;
    int   len;
    logic lvl;
    int   np;
    int   nr;
    int   nl;
  } seg_t;

  typedef struct {
    int cyc;
    int kind;
  } evt_t;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cnt_press, cnt_release, cnt_long;
  int overlap_seen = 0;
  bit exact = 1'b0;

  evt_t evq[$];
  seg_t sbq[$];
  seg_t segs[16];

  button_debounce #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG),
    .ACTIVE_LOW  (1)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; outputs at the following negedge belong to cycle cyc.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_evt(input int kind);
    evt_t e;
    n_tests++;
    if (evq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected pulse kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = evq.pop_front();
      if (e.cyc != cyc || e.kind != kind) begin
        n_fail++;
        $display("FAIL pulse kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Pulse monitor: counts pulses and, in exact mode, matches them against the event queue.
  always @(negedge clk) begin
    if (btn_press && btn_release) overlap_seen++;
    if (btn_press) cnt_press++;
    if (btn_release) cnt_release++;
    if (btn_long) cnt_long++;
    if (exact) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed pulse kind %0d: got none, expected at cycle %0d",
                 evq[0].kind, evq[0].cyc);
        void'(evq.pop_front());
      end
      if (btn_press) check_evt(KPress);
      if (btn_release) check_evt(KRelease);
      if (btn_long) check_evt(KLong);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push_evt(input int c, input int kind);
    evt_t e;
    e.cyc  = c;
    e.kind = kind;
    evq.push_back(e);
  endtask

  initial begin
    seg_t s;
    int   k, k2, p;

    reset   = 1'b1;
    btn_raw = 1'b1;

    // Stimulus/expectation table: raw level, cycles, level at end, pulse counts in segment.
    segs[0] = '{1'b1, 8, 1'b0, 0, 0, 0};
    for (int b = 0; b < 5; b++) begin
      segs[1 + 2 * b] = '{1'b0, 3, 1'b0, 0, 0, 0};
      segs[2 + 2 * b] = '{1'b1, 3, 1'b0, 0, 0, 0};
    end
    segs[11] = '{1'b1, 6, 1'b0, 0, 0, 0};
    segs[12] = '{1'b0, 12, 1'b1, 1, 0, 0};
    segs[13] = '{1'b1, 2, 1'b1, 0, 0, 0};
    segs[14] = '{1'b0, 4, 1'b1, 0, 0, 0};
    segs[15] = '{1'b1, 10, 1'b0, 0, 1, 0};

    // Reset state.
    repeat (3) tick();
    chk("reset_level", int'(btn_level), 0);
    chk("reset_press", int'(btn_press), 0);
    chk("reset_release", int'(btn_release), 0);
    chk("reset_long", int'(btn_long), 0);
    reset = 1'b0;

    // Table-driven segments: clean idle, bounce rejection, press, release glitch, release.
    for (int i = 0; i < 16; i++) begin
      btn_raw     = segs[i].raw;
      cnt_press   = 0;
      cnt_release = 0;
      cnt_long    = 0;
      sbq.push_back(segs[i]);
      repeat (segs[i].len) tick();
      s = sbq.pop_front();
      chk($sformatf("seg%0d_level", i), int'(btn_level), int'(s.lvl));
      chk($sformatf("seg%0d_press", i), cnt_press, s.np);
      chk($sformatf("seg%0d_release", i), cnt_release, s.nr);
      chk($sformatf("seg%0d_long", i), cnt_long, s.nl);
    end

    // Exact latency: clean press, long hold, release.
    exact   = 1'b1;
    btn_raw = 1'b1;
    repeat (4) tick();
    btn_raw = 1'b0;
    k = cyc + 1;
    push_evt(k + 2 + DB, KPress);
`ifdef BUTTON_DEBOUNCE_LONG_EN
    push_evt(k + 2 + DB + LONG - 1, KLong);
`endif
    wait_until(k + 1 + DB);
    chk("level_before_press", int'(btn_level), 0);
    tick();
    chk("level_at_press", int'(btn_level), 1);
    wait_until(k + 2 + DB + 40);
    chk("level_held", int'(btn_level), 1);
    btn_raw = 1'b1;
    k2 = cyc + 1;
    push_evt(k2 + 2 + DB, KRelease);
    wait_until(k2 + 2 + DB + 4);
    chk("long_seq_events_left", evq.size(), 0);
    chk("level_after_release", int'(btn_level), 0);

    // Reset two cycles after the press while held, then re-debounce from idle.
    btn_raw = 1'b0;
    k = cyc + 1;
    p = k + 2 + DB;
    push_evt(p, KPress);
    wait_until(p + 1);
    reset = 1'b1;
    tick();
    chk("midreset_level", int'(btn_level), 0);
    chk("midreset_press", int'(btn_press), 0);
    chk("midreset_release", int'(btn_release), 0);
    chk("midreset_long", int'(btn_long), 0);
    reset = 1'b0;
    push_evt(p + 3 + 2 + DB, KPress);
    wait_until(p + 3 + 2 + DB + 5);
    chk("midreset_events_left", evq.size(), 0);
    chk("midreset_level_again", int'(btn_level), 1);
    btn_raw = 1'b1;
    k2 = cyc + 1;
    push_evt(k2 + 2 + DB, KRelease);
    wait_until(k2 + 2 + DB + 3);
    chk("final_events_left", evq.size(), 0);
    chk("pulse_overlap", overlap_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 1000000 (20 ms at 50 MHz): consecutive stable samples required to accept a level change.
REQ-002 SHALL provide parameter LONG_CYCLES, default 50000000 (1 s): debounced-pressed duration that triggers a long-press event.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: when 1, raw input low means pressed.
REQ-004 SHALL have port CLOCK_50, input, 1, the single system clock (50 MHz).
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port btn_raw, input, 1, asynchronous bouncing pushbutton pin.
REQ-007 SHALL have port btn_level, output, 1, debounced pressed level (1 = pressed).
REQ-008 SHALL have port btn_press, output, 1, one-cycle pulse on accepted press.
REQ-009 SHALL have port btn_release, output, 1, one-cycle pulse on accepted release.
REQ-010 SHALL have port btn_long, output, 1, one-cycle pulse on long press.

Function
REQ-011 SHALL pass btn_raw through a 2-flop synchronizer, then polarity-normalize it to internal signal pressed_s.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, and RELEASE_WAIT, plus a debounce counter sized to hold DB_CYCLES.
REQ-013 IDLE: when pressed_s=1, SHALL go to PRESS_WAIT with counter cleared; otherwise SHALL stay in IDLE.
REQ-014 PRESS_WAIT: when pressed_s=0, SHALL return to IDLE with no output event (bounce rejected); otherwise SHALL increment the counter.
REQ-015 PRESS_WAIT: when the counter reaches DB_CYCLES-1 with pressed_s=1, SHALL go to PRESSED, set btn_level=1, and pulse btn_press for exactly one cycle.
REQ-016 PRESSED: when pressed_s=0, SHALL go to RELEASE_WAIT with counter cleared.
REQ-017 RELEASE_WAIT: when pressed_s=1, SHALL return to PRESSED with no btn_press pulse and btn_level held at 1.
REQ-018 RELEASE_WAIT: when pressed_s=0 for DB_CYCLES consecutive cycles, SHALL go to IDLE, clear btn_level, and pulse btn_release once.
REQ-019 Latency: with btn_raw stable after an edge sampled at cycle k, btn_press (or btn_release) SHALL be high in cycle k+2+DB_CYCLES.
REQ-020 Pulses SHALL never overlap: btn_press and btn_release are never high in the same cycle.
REQ-021 A held button SHALL produce exactly one btn_press; no auto-repeat.
REQ-022 Counters SHALL saturate and never wrap, whatever the hold duration.

Reset
REQ-023 With reset=1 at a CLOCK_50 rising edge, SHALL enter IDLE, clear all counters and synchronizer flops to the not-pressed value, and drive all outputs to 0 on the next cycle.
REQ-024 Reset asserted mid-press (any state) SHALL suppress all pulses; after release of reset, a still-held button SHALL be re-debounced from IDLE and then emit btn_press.
REQ-025 SHALL have no asynchronous reset path.

Configuration
REQ-026 Macro BUTTON_DEBOUNCE_LONG_EN SHALL control the long-press feature.
REQ-027 With BUTTON_DEBOUNCE_LONG_EN defined: a long counter SHALL clear on the btn_press pulse and count while btn_level=1, including in RELEASE_WAIT.
REQ-028 With BUTTON_DEBOUNCE_LONG_EN defined: btn_long SHALL pulse once when the long counter reaches LONG_CYCLES-1, then saturate with no further pulse until the next press.
REQ-029 Without BUTTON_DEBOUNCE_LONG_EN: btn_long SHALL be tied to 0, and no long counter SHALL be synthesized.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding (2-bit), the default DB_CYCLES and LONG_CYCLES constants, and the CLOCK_50 frequency constant 50000000.
REQ-031 The synchronizer SHALL be a sub-module named sync_2ff (1-bit, reset value parameterized), reusable by other stages.
REQ-032 btn_press SHALL be directly usable as the toggle/clear request of the downstream LED blink stage.

Verification (DB_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1 unless noted)
REQ-033 Clean press: btn_raw 1->0 at cycle 10, held -> btn_press high only at cycle 16, btn_level=1 from cycle 16.
REQ-034 Bounce reject: btn_raw low for 3 cycles, then high, repeated 5 times -> no btn_press, btn_level stays 0.
REQ-035 Release glitch: while pressed, 2-cycle high glitch on btn_raw -> no btn_release, no second btn_press, btn_level stays 1.
REQ-036 Long press (macro defined): hold 40 cycles after btn_press -> exactly one btn_long, 19 cycles after btn_press; release -> one btn_release. Macro undefined: btn_long is never 1.
REQ-037 Reset mid-press: assert reset 2 cycles after btn_press while held, deassert 1 cycle later -> outputs 0 during reset, then btn_press again DB_CYCLES+2 cycles after reset is deasserted.
REQ-038 Default parameters: one clean press -> btn_press exactly 1000002 cycles after the edge.
